// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, LSB first, fixed baud set by CLKS_PER_BIT.
//
// Ports:
//   clk          system clock
//   reset        synchronous reset, active-high
//   rx           asynchronous serial line, idle high
//   data_out     last correctly received byte, held until the next good byte
//   valid        one-cycle strobe; data_out is new in the same cycle
//   framing_err  one-cycle strobe; stop bit was sampled low (byte discarded)
//   busy         high in every state except idle
//
// After reset or a framing error the receiver waits for one full bit time of
// continuous high line before it will accept a start bit. This keeps a held
// break from being decoded as a stream of zero bytes.

module uart_rx #(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] data_out,
   output logic       valid,
   output logic       framing_err,
   output logic       busy
);

   localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
   localparam int unsigned CntW     = $clog2(CLKS_PER_BIT);

   localparam logic [CntW-1:0] CntBitEnd = CntW'(CLKS_PER_BIT - 1);
   localparam logic [CntW-1:0] CntHalf   = CntW'(HALF_BIT - 1);

   typedef enum logic [2:0] {
      StWaitIdle,
      StIdle,
      StStart,
      StData,
      StStop
   } state_e;

   // Two-flop synchronizer; resets to the idle (high) line level.
   logic rx_meta_q;
   logic rx_s_q;

   state_e          state_q,   state_d;
   logic [CntW-1:0] cnt_q,     cnt_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic [7:0]      shift_q,   shift_d;
   logic [7:0]      data_q,    data_d;
   logic            valid_q,   valid_d;
   logic            ferr_q,    ferr_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StWaitIdle;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + 1'b1;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      ferr_d    = 1'b0;

      unique case (state_q)
         StWaitIdle: begin
            // Count consecutive high cycles; any low restarts the count.
            if (!rx_s_q) begin
               cnt_d = '0;
            end else if (cnt_q == CntBitEnd) begin
               state_d = StIdle;
               cnt_d   = '0;
            end
         end

         StIdle: begin
            // Counter free-runs here; it is cleared on the way into start.
            if (!rx_s_q) begin
               state_d = StStart;
               cnt_d   = '0;
            end
         end

         StStart: begin
            // Re-check the line at mid start bit to reject short glitches.
            if (cnt_q == CntHalf) begin
               cnt_d = '0;
               if (!rx_s_q) begin
                  state_d   = StData;
                  bit_idx_d = '0;
               end else begin
                  state_d = StIdle;
               end
            end
         end

         StData: begin
            // Counter is restarted for each bit so non-power-of-two
            // divisors keep every sample a whole bit period apart.
            if (cnt_q == CntBitEnd) begin
               cnt_d              = '0;
               shift_d[bit_idx_q] = rx_s_q;
               bit_idx_d          = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
                  state_d = StStop;
               end
            end
         end

         StStop: begin
            // Leaving at mid stop bit gives half a bit of slack for a
            // start bit that follows with no idle gap.
            if (cnt_q == CntBitEnd) begin
               cnt_d = '0;
               if (rx_s_q) begin
                  state_d = StIdle;
                  data_d  = shift_q;
                  valid_d = 1'b1;
               end else begin
                  state_d = StWaitIdle;
                  ferr_d  = 1'b1;
               end
            end
         end

         default: begin
            state_d = StWaitIdle;
            cnt_d   = '0;
         end
      endcase
   end

   assign data_out    = data_q;
   assign valid       = valid_q;
   assign framing_err = ferr_q;
   assign busy        = (state_q != StIdle);

   a_pulse_excl: assert property (@(posedge clk) disable iff (reset)
      !(valid && framing_err));
   a_valid_single: assert property (@(posedge clk) disable iff (reset)
      valid |=> !valid);
   a_ferr_single: assert property (@(posedge clk) disable iff (reset)
      framing_err |=> !framing_err);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx at 16 clocks per bit.
// The reference model works at frame level: every frame the bench sends
// produces an expected event (good byte or framing error) with the start time,
// and a monitor collects the strobes the receiver actually produces.

module tb_uart_rx;

   localparam int unsigned Cpb    = 16;
   localparam int unsigned LatNom = (Cpb * 19) / 2 + 3;  // 9.5 bit times + 3

   logic       clk = 1'b0;
   logic       reset;
   logic       rx;
   logic [7:0] data_out;
   logic       valid;
   logic       framing_err;
   logic       busy;

   typedef struct packed {
      logic        is_err;
      logic [7:0]  data;
      logic [31:0] cyc;
   } ev_t;

   ev_t got_q[$];
   ev_t exp_q[$];

   int unsigned n_cmp     = 0;
   int unsigned n_err     = 0;
   int unsigned cyc       = 0;
   int unsigned busy_run  = 0;
   int unsigned busy_max  = 0;
   logic [7:0]  last_good = 8'h00;

   uart_rx #(
      .CLKS_PER_BIT(Cpb)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .rx         (rx),
      .data_out   (data_out),
      .valid      (valid),
      .framing_err(framing_err),
      .busy       (busy)
   );

   initial forever #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (obs !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Monitor: records strobes and enforces the pulse rules every cycle.
   initial begin : monitor
      logic prev_valid;
      logic prev_ferr;
      ev_t  e;
      prev_valid = 1'b0;
      prev_ferr  = 1'b0;
      forever begin
         @(negedge clk);
         if (valid || framing_err) begin
            check("pulse_excl", {31'd0, valid & framing_err}, 32'd0);
            e.is_err = framing_err;
            e.data   = data_out;
            e.cyc    = cyc;
            got_q.push_back(e);
         end
         if (valid) check("valid_width", {31'd0, prev_valid}, 32'd0);
         if (framing_err) check("ferr_width", {31'd0, prev_ferr}, 32'd0);
         prev_valid = valid;
         prev_ferr  = framing_err;
         busy_run   = busy ? busy_run + 1 : 0;
         if (busy_run > busy_max) busy_max = busy_run;
      end
   end

   task automatic hold(input logic v, input int unsigned n);
      rx = v;
      if (n > 0) begin
         repeat (n) @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop, input int unsigned gap);
      ev_t e;
      e.cyc    = cyc;
      e.is_err = ~stop;
      e.data   = stop ? b : last_good;
      hold(1'b0, Cpb);
      for (int i = 0; i < 8; i++) hold(b[i], Cpb);
      hold(stop, Cpb);
      if (stop) last_good = b;
      exp_q.push_back(e);
      hold(1'b1, gap);
   endtask

   task automatic compare_events(input string tag);
      int unsigned lat;
      check({tag, "_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         lat = got_q[i].cyc - exp_q[i].cyc;
         check({tag, "_kind"}, {31'd0, got_q[i].is_err}, {31'd0, exp_q[i].is_err});
         check({tag, "_data"}, {24'd0, got_q[i].data}, {24'd0, exp_q[i].data});
         check({tag, "_latency_ok"}, {31'd0, (lat + 1 >= LatNom) && (lat <= LatNom + 1)},
               32'd1);
      end
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin : stim
      ev_t         brk;
      logic [7:0]  b;
      logic        bad;
      int unsigned gap;

      reset = 1'b1;
      rx    = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("rst_data", {24'd0, data_out}, 32'h00);
      check("rst_valid", {31'd0, valid}, 32'd0);
      check("rst_ferr", {31'd0, framing_err}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd1);

      // Reset exit
      reset = 1'b0;
      hold(1'b1, 40);
      check("exit_busy_idle", {31'd0, busy}, 32'd0);
      send_frame(8'hA5, 1'b1, 20);
      check("exit_data", {24'd0, data_out}, 32'hA5);
      check("exit_busy_end", {31'd0, busy}, 32'd0);
      compare_events("exit");

      // Back-to-back frames, no idle between stop and next start
      send_frame(8'h00, 1'b1, 0);
      send_frame(8'hFF, 1'b1, 0);
      send_frame(8'h3C, 1'b1, 20);
      check("b2b_n", got_q.size(), 32'd3);
      for (int i = 1; i < got_q.size(); i++) begin
         check("b2b_spacing", got_q[i].cyc - got_q[i-1].cyc, 10 * Cpb);
      end
      compare_events("b2b");

      // Glitch rejection
      busy_max = 0;
      hold(1'b0, 5);
      hold(1'b1, 40);
      check("glitch_busy_le10", {31'd0, busy_max <= 10}, 32'd1);
      check("glitch_busy_seen", {31'd0, busy_max > 0}, 32'd1);
      check("glitch_busy_end", {31'd0, busy}, 32'd0);
      compare_events("glitch");

      // Framing error, then recovery
      send_frame(8'h55, 1'b0, 40);
      check("ferr_data_held", {24'd0, data_out}, {24'd0, last_good});
      compare_events("ferr");
      send_frame(8'h81, 1'b1, 20);
      compare_events("ferr_next");

      // Break: line low for 300 cycles
      brk.cyc    = cyc;
      brk.is_err = 1'b1;
      brk.data   = last_good;
      hold(1'b0, 300);
      hold(1'b1, 10);
      check("brk_busy_early", {31'd0, busy}, 32'd1);
      hold(1'b1, 20);
      check("brk_busy_end", {31'd0, busy}, 32'd0);
      exp_q.push_back(brk);
      compare_events("brk");
      send_frame(8'h42, 1'b1, 20);
      compare_events("brk_next");

      // Reset during data bit 4 of 0xC3
      hold(1'b0, Cpb);
      for (int i = 0; i < 4; i++) begin
         b = 8'hC3;
         hold(b[i], Cpb);
      end
      hold(1'b0, 8);
      reset = 1'b1;
      hold(1'b0, 3);
      check("mid_rst_data", {24'd0, data_out}, 32'h00);
      check("mid_rst_busy", {31'd0, busy}, 32'd1);
      last_good = 8'h00;
      reset = 1'b0;
      hold(1'b0, 10);
      check("mid_busy_low_line", {31'd0, busy}, 32'd1);
      hold(1'b1, 10);
      check("mid_busy_short_high", {31'd0, busy}, 32'd1);
      hold(1'b1, 20);
      check("mid_busy_end", {31'd0, busy}, 32'd0);
      compare_events("mid_rst");
      send_frame(8'h99, 1'b1, 20);
      compare_events("mid_next");

      // Randomized frames with occasional bad stop bits
      for (int k = 0; k < 40; k++) begin
         b   = 8'($urandom);
         bad = ($urandom_range(7) == 0);
         gap = bad ? $urandom_range(40, 20) : $urandom_range(20, 0);
         send_frame(b, ~bad, gap);
      end
      hold(1'b1, 30);
      check("rand_data_final", {24'd0, data_out}, {24'd0, last_good});
      compare_events("rand");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
